// File: rtl/inst_fetch.sv
// Instruction fetch unit: PC handshake in, single outstanding AXI-style read, decode handshake out.
// Optional perf counters (fetch_cnt_o, stall_cnt_o) exist when YSYX_23060251_IFU_PERF_EN is defined.
module inst_fetch #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              pc_valid_i,
    output logic              pc_ready_o,
    output logic [ADDR_W-1:0] araddr_o,
    output logic              arvalid_o,
    input  logic              arready_i,
    input  logic [DATA_W-1:0] rdata_i,
    input  logic [1:0]        rresp_i,
    input  logic              rvalid_i,
    output logic              rready_o,
    output logic [DATA_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_pc_o,
    output logic              inst_valid_o,
    input  logic              inst_ready_i,
    output logic [1:0]        fault_o
`ifdef YSYX_23060251_IFU_PERF_EN
    ,
    output logic [31:0]       fetch_cnt_o,
    output logic [31:0]       stall_cnt_o
`endif
);

    localparam logic [DATA_W-1:0] NOP_INST = DATA_W'(32'h0000_0013);

    typedef enum logic [1:0] {StIdle, StReq, StWaitR, StHold} state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_inst;
    logic [1:0]        r_fault;
    logic              w_accept;
    logic              w_aligned;

    assign pc_ready_o = (r_state == StIdle) || ((r_state == StHold) && inst_ready_i);
    assign w_accept   = pc_valid_i && pc_ready_o;
    assign w_aligned  = (pc_i[1:0] == 2'b00);

    // Handshake strobes decode the state register only, never an input.
    assign arvalid_o    = (r_state == StReq);
    assign rready_o     = (r_state == StWaitR);
    assign inst_valid_o = (r_state == StHold);
    assign araddr_o     = r_pc;
    assign inst_pc_o    = r_pc;
    assign inst_o       = r_inst;
    assign fault_o      = r_fault;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= StIdle;
            r_pc    <= '0;
            r_inst  <= '0;
            r_fault <= 2'b00;
        end else begin
            unique case (r_state)
                StReq: begin
                    if (arready_i) r_state <= StWaitR;
                end
                StWaitR: begin
                    if (rvalid_i) begin
                        r_inst  <= rdata_i;
                        r_fault <= (rresp_i != 2'b00) ? 2'b10 : 2'b00;
                        r_state <= StHold;
                    end
                end
                StHold: begin
                    if (inst_ready_i && !pc_valid_i) r_state <= StIdle;
                end
                default: ;
            endcase
            // New PC from IDLE or back-to-back from HOLD; misaligned PCs skip the bus.
            if (w_accept) begin
                r_pc <= pc_i;
                if (w_aligned) begin
                    r_fault <= 2'b00;
                    r_state <= StReq;
                end else begin
                    r_inst  <= NOP_INST;
                    r_fault <= 2'b01;
                    r_state <= StHold;
                end
            end
        end
    end

`ifdef YSYX_23060251_IFU_PERF_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_fetch_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if ((r_state == StHold) && inst_ready_i) r_fetch_cnt <= r_fetch_cnt + 32'd1;
            if ((r_state == StReq) || (r_state == StWaitR)) r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign fetch_cnt_o = r_fetch_cnt;
    assign stall_cnt_o = r_stall_cnt;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a transaction-queue reference model checked every cycle.
module tb_inst_fetch;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] pc_i;
    logic        pc_valid_i;
    logic        pc_ready_o;
    logic [31:0] araddr_o;
    logic        arvalid_o;
    logic        arready_i;
    logic [31:0] rdata_i;
    logic [1:0]  rresp_i;
    logic        rvalid_i;
    logic        rready_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [1:0]  fault_o;
`ifdef YSYX_23060251_IFU_PERF_EN
    logic [31:0] fetch_cnt_o;
    logic [31:0] stall_cnt_o;
    logic [31:0] s0;
    logic [31:0] f0;
`endif

    inst_fetch #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .pc_i(pc_i), .pc_valid_i(pc_valid_i), .pc_ready_o(pc_ready_o),
        .araddr_o(araddr_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
        .rdata_i(rdata_i), .rresp_i(rresp_i), .rvalid_i(rvalid_i), .rready_o(rready_o),
        .inst_o(inst_o), .inst_pc_o(inst_pc_o), .inst_valid_o(inst_valid_o),
        .inst_ready_i(inst_ready_i), .fault_o(fault_o)
`ifdef YSYX_23060251_IFU_PERF_EN
        , .fetch_cnt_o(fetch_cnt_o), .stall_cnt_o(stall_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [1:0]  fault;
    } exp_t;
    exp_t q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // What the decode side must see for a PC, derived from the fetch rules alone.
    function automatic exp_t model(input logic [31:0] pc, input logic [31:0] rd,
                                   input logic [1:0] rr);
        exp_t e;
        e.pc = pc;
        if (pc[1:0] != 2'b00) begin
            e.inst  = 32'h0000_0013;
            e.fault = 2'b01;
        end else begin
            e.inst  = rd;
            e.fault = (rr != 2'b00) ? 2'b10 : 2'b00;
        end
        return e;
    endfunction

    always @(posedge clk_i) begin
        if (rst_i) q.delete();
        else if (inst_valid_o && inst_ready_i && q.size() > 0) void'(q.pop_front());
    end

    always @(negedge clk_i) begin
        if (rst_i) begin
            q.delete();
        end else begin
            if (arvalid_o) begin
                if (q.size() == 0) check("unexpected_arvalid", arvalid_o, 1'b0);
                else begin
                    check("araddr_vs_model", araddr_o, q[0].pc);
                    if (q[0].pc[1:0] != 2'b00) check("no_bus_on_misalign", arvalid_o, 1'b0);
                end
            end
            if (inst_valid_o) begin
                if (q.size() == 0) check("unexpected_inst_valid", inst_valid_o, 1'b0);
                else begin
                    check("inst_vs_model", inst_o, q[0].inst);
                    check("inst_pc_vs_model", inst_pc_o, q[0].pc);
                    check("fault_vs_model", fault_o, q[0].fault);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Present a PC and complete the handshake; returns in cycle 1 of the fetch.
    task automatic accept(input logic [31:0] pc, input logic [31:0] rd, input logic [1:0] rr);
        bit ok = 0;
        pc_i       = pc;
        pc_valid_i = 1'b1;
        rdata_i    = rd;
        rresp_i    = rr;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            if (pc_ready_o) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            n_total++;
            $display("FAIL accept_timeout: pc_ready_o never rose for pc 0x%0h", pc);
        end else q.push_back(model(pc, rd, rr));
        tick();
        pc_valid_i   = 1'b0;
        inst_ready_i = 1'b0;
    endtask

    // Bus responder: holds off arready/rvalid for the given cycles, eager keeps both high.
    task automatic run(input int ar_wait, input int r_wait, input bit eager, input int exp_lat);
        int cyc    = 1;
        int ar_seen = 0;
        int r_seen  = 0;
        while (!inst_valid_o && cyc < 60) begin
            if (eager) begin
                arready_i = 1'b1;
                rvalid_i  = 1'b1;
            end else begin
                arready_i = arvalid_o && (ar_seen >= ar_wait);
                rvalid_i  = rready_o && (r_seen >= r_wait);
            end
            if (arvalid_o) ar_seen++;
            if (rready_o) r_seen++;
            tick();
            cyc++;
        end
        arready_i = 1'b0;
        rvalid_i  = 1'b0;
        check("latency", cyc, exp_lat);
    endtask

    task automatic release_inst();
        inst_ready_i = 1'b1;
        @(negedge clk_i);
        check("pc_ready_on_release", pc_ready_o, 1'b1);
        tick();
        inst_ready_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1; pc_i = '0; pc_valid_i = 1'b0; arready_i = 1'b0;
        rdata_i = '0; rresp_i = 2'b00; rvalid_i = 1'b0; inst_ready_i = 1'b0;
        #1;
        check("rst_arvalid", arvalid_o, 1'b0);
        check("rst_rready", rready_o, 1'b0);
        check("rst_inst_valid", inst_valid_o, 1'b0);
        check("rst_inst", inst_o, 32'h0);
        check("rst_araddr", araddr_o, 32'h0);
        check("rst_fault", fault_o, 2'b00);
        check("rst_pc_ready", pc_ready_o, 1'b1);
        tick(); tick();
        rst_i = 1'b0;
        tick();

        // Single fetch with both bus strobes held high from cycle 1.
`ifdef YSYX_23060251_IFU_PERF_EN
        s0 = stall_cnt_o; f0 = fetch_cnt_o;
`endif
        accept(32'h8000_0000, 32'h0010_0073, 2'b00);
        check("req_arvalid", arvalid_o, 1'b1);
        check("req_araddr", araddr_o, 32'h8000_0000);
        run(0, 0, 1'b1, 3);
        check("single_inst", inst_o, 32'h0010_0073);
        check("single_pc", inst_pc_o, 32'h8000_0000);
        check("single_fault", fault_o, 2'b00);
        release_inst();
`ifdef YSYX_23060251_IFU_PERF_EN
        check("stall_single", stall_cnt_o - s0, 32'd2);
        check("fetch_single", fetch_cnt_o - f0, 32'd1);
`endif
        tick();

        // Bus wait: 4 cycles of arready low, 3 cycles of rvalid low.
`ifdef YSYX_23060251_IFU_PERF_EN
        s0 = stall_cnt_o;
`endif
        accept(32'h8000_0020, 32'h0000_0093, 2'b00);
        run(4, 3, 1'b0, 10);
`ifdef YSYX_23060251_IFU_PERF_EN
        check("stall_bus_wait", stall_cnt_o - s0, 32'd9);
`endif
        release_inst();

        // Misaligned PC: straight to HOLD with a NOP and fault 01.
`ifdef YSYX_23060251_IFU_PERF_EN
        s0 = stall_cnt_o;
`endif
        accept(32'h8000_0002, 32'hffff_ffff, 2'b00);
        run(0, 0, 1'b0, 1);
        check("misalign_inst", inst_o, 32'h0000_0013);
        check("misalign_fault", fault_o, 2'b01);
        check("misalign_arvalid", arvalid_o, 1'b0);
`ifdef YSYX_23060251_IFU_PERF_EN
        check("stall_misalign", stall_cnt_o - s0, 32'd0);
`endif
        release_inst();

        // Bus error, stalled decode for 5 cycles, then back-to-back accept.
        accept(32'h8000_0000, 32'h1234_5678, 2'b10);
        run(0, 0, 1'b0, 3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            check("hold_valid", inst_valid_o, 1'b1);
            check("hold_inst", inst_o, 32'h1234_5678);
            check("hold_fault", fault_o, 2'b10);
            check("hold_pc", inst_pc_o, 32'h8000_0000);
            check("hold_pc_ready", pc_ready_o, 1'b0);
            tick();
        end
`ifdef YSYX_23060251_IFU_PERF_EN
        f0 = fetch_cnt_o;
`endif
        inst_ready_i = 1'b1;
        accept(32'h8000_0004, 32'h00a0_0093, 2'b00);
        check("b2b_arvalid", arvalid_o, 1'b1);
        check("b2b_araddr", araddr_o, 32'h8000_0004);
        run(0, 0, 1'b0, 3);
        check("b2b_inst", inst_o, 32'h00a0_0093);
        check("b2b_fault", fault_o, 2'b00);
        release_inst();
`ifdef YSYX_23060251_IFU_PERF_EN
        check("fetch_b2b", fetch_cnt_o - f0, 32'd2);
`endif

        // Reset in WAIT_R abandons the read; a late rvalid must be ignored.
        accept(32'h8000_0010, 32'h1111_1111, 2'b00);
        arready_i = 1'b1;
        tick();
        arready_i = 1'b0;
        @(negedge clk_i);
        check("wait_rready", rready_o, 1'b1);
        tick();
        rst_i = 1'b1;
        #1;
        check("rstw_arvalid", arvalid_o, 1'b0);
        check("rstw_rready", rready_o, 1'b0);
        check("rstw_inst_valid", inst_valid_o, 1'b0);
        check("rstw_araddr", araddr_o, 32'h0);
        tick();
        rst_i    = 1'b0;
        rvalid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            check("late_inst_valid", inst_valid_o, 1'b0);
            check("late_rready", rready_o, 1'b0);
            check("late_arvalid", arvalid_o, 1'b0);
            tick();
        end
        rvalid_i = 1'b0;
`ifdef YSYX_23060251_IFU_PERF_EN
        check("rst_fetch_cnt", fetch_cnt_o, 32'd0);
        check("rst_stall_cnt", stall_cnt_o, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter ADDR_W, default 32, SHALL set the PC and bus address width.
REQ-002 Parameter DATA_W, default 32, SHALL set the instruction and bus data width.
REQ-003 clk_i  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst_i  input  1  SHALL be the reset, asynchronous and active-high.
REQ-005 pc_i  input  ADDR_W  SHALL carry the fetch address from the PC unit.
REQ-006 pc_valid_i  input  1  SHALL indicate pc_i is valid.
REQ-007 pc_ready_o  output  1  SHALL indicate the block accepts pc_i this cycle.
REQ-008 araddr_o  output  ADDR_W, arvalid_o  output  1, arready_i  input  1  SHALL form the read-address channel.
REQ-009 rdata_i  input  DATA_W, rresp_i  input  2, rvalid_i  input  1, rready_o  output  1  SHALL form the read-data channel.
REQ-010 inst_o  output  DATA_W, inst_pc_o  output  ADDR_W, inst_valid_o  output  1, inst_ready_i  input  1  SHALL form the decode-side handshake.
REQ-011 fault_o  output  2  SHALL carry the fault code for inst_o: 00 none, 01 misaligned, 10 bus error.

Function
REQ-012 The FSM SHALL have states IDLE, REQ, WAIT_R and HOLD.
REQ-013 pc_ready_o SHALL be 1 in IDLE, and 1 in HOLD when inst_ready_i=1; otherwise 0.
REQ-014 On a pc_valid_i & pc_ready_o handshake, pc_i SHALL be latched. The FSM SHALL go to REQ if pc_i[1:0]==0; otherwise it SHALL go to HOLD with fault_o=01 and inst_o=0x00000013, and no bus request SHALL be issued.
REQ-015 In REQ, arvalid_o SHALL be 1 and araddr_o SHALL equal the latched PC, stable until arready_i=1. The FSM SHALL then go to WAIT_R.
REQ-016 In WAIT_R, rready_o SHALL be 1. On rvalid_i=1, rdata_i SHALL be latched into inst_o and the FSM SHALL go to HOLD. fault_o SHALL be 10 if rresp_i!=0, else 00.
REQ-017 In HOLD, inst_valid_o SHALL be 1, with inst_o, inst_pc_o and fault_o held stable until inst_ready_i=1.
REQ-018 On HOLD & inst_ready_i: with pc_valid_i=1, the next PC SHALL be accepted in the same cycle (back-to-back); otherwise the FSM SHALL go to IDLE.
REQ-019 arvalid_o, rready_o and inst_valid_o SHALL each be driven only from the current state (registered, no combinational path from *_i).
REQ-020 Minimum latency, with arready_i and rvalid_i asserted on first opportunity: PC accepted at cycle 0, inst_valid_o=1 at cycle 3.
REQ-021 rvalid_i outside WAIT_R and arready_i outside REQ SHALL be ignored.

Reset
REQ-022 rst_i=1 SHALL immediately force IDLE with arvalid_o=0, rready_o=0, inst_valid_o=0, inst_o=0, inst_pc_o=0, araddr_o=0, fault_o=00 and counters=0.
REQ-023 Reset during REQ or WAIT_R SHALL abandon the transaction; a late rvalid_i after reset SHALL NOT produce inst_valid_o.

Configuration
REQ-024 With YSYX_23060251_IFU_PERF_EN defined, these outputs SHALL exist:
- fetch_cnt_o (32 bits): +1 per HOLD & inst_ready_i.
- stall_cnt_o (32 bits): +1 per cycle in REQ or WAIT_R.
Both counters SHALL wrap 0xFFFFFFFF->0.
REQ-025 Without YSYX_23060251_IFU_PERF_EN, those ports and their counters SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-026 Single fetch: pc_i=0x80000000, arready_i=1, rvalid_i=1 with rdata_i=0x00100073, rresp_i=0 -> inst_valid_o at cycle 3, inst_o=0x00100073, inst_pc_o=0x80000000, fault_o=00.
REQ-027 Bus wait: arready_i low 4 cycles, rvalid_i low 3 cycles -> araddr_o stable throughout; inst_valid_o after 7 extra cycles; stall_cnt_o=9 (PERF_EN).
REQ-028 Misaligned pc_i=0x80000002 -> arvalid_o never asserts; HOLD with fault_o=01, inst_o=0x00000013.
REQ-029 Bus error rresp_i=2'b10 -> fault_o=10; inst_ready_i=0 for 5 cycles -> outputs stable; then back-to-back pc_i=0x80000004 accepted in the same cycle as inst_ready_i.
REQ-030 rst_i pulsed during WAIT_R, then rvalid_i=1 -> arvalid_o=0, rready_o=0, inst_valid_o stays 0; fetch_cnt_o=0.
